// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 32-bit shifter for the ALU shift path.
// Applies the power-of-two stages 16, 8, 4, 2, 1 one per clock (SLL/SRL/SRA).
// busy is high while stages are applied; done pulses once when result is final.
module shift_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q,   acc_d;
  logic [4:0]  amt_q,   amt_d;
  logic [1:0]  opr_q,   opr_d;
  logic [2:0]  stage_q, stage_d;

  logic [4:0]  step_amt;
  logic [31:0] stage_val;

  // Value of acc after applying the current stage's weight (2^stage).
  always_comb begin
    step_amt = 5'd1 << stage_q;
    case (opr_q)
      2'b00:   stage_val = acc_q << step_amt;
      2'b10:   stage_val = acc_q >> step_amt;
      default: stage_val = $unsigned($signed(acc_q) >>> step_amt);
    endcase
  end

  // Next-state and datapath update; flush wins over start and freezes acc.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    opr_d   = opr_q;
    stage_d = stage_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc_d   = data_in;
            amt_d   = shamt;
            opr_d   = op;
            stage_d = 3'd4;
            state_d = (shamt == 5'd0) ? S_DONE : S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (amt_q[stage_q]) begin
            acc_d = stage_val;
          end
          if (stage_q == 3'd0) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q - 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      opr_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      opr_q   <= opr_d;
      stage_q <= stage_d;
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    result = acc_q;
    busy   = (state_q == S_SHIFT);
    done   = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer: vector table plus hand-written
// sequences for flush, ignored start, back-to-back start and mid-shift reset.
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int unsigned n_checks;
  int unsigned n_fail;

  shift_sequencer dut (
    .clock   (clk),
    .reset   (reset),
    .start   (start),
    .flush   (flush),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
    int unsigned lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled there too.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_start(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
    start   = 1'b1;
    op      = o;
    data_in = d;
    shamt   = s;
  endtask

  task automatic run_vec(input vec_t v, input int unsigned idx);
    drive_start(v.op, v.data, v.shamt);
    step();
    start = 1'b0;
    for (int unsigned c = 1; c <= v.lat; c++) begin
      check($sformatf("v%0d busy c%0d", idx, c), {31'd0, busy}, {31'd0, (c < v.lat)});
      check($sformatf("v%0d done c%0d", idx, c), {31'd0, done}, {31'd0, (c == v.lat)});
      if (c == v.lat) check($sformatf("v%0d result", idx), result, v.exp);
      if (c < v.lat) step();
    end
    step();
    check($sformatf("v%0d done drop", idx), {31'd0, done}, 32'd0);
    check($sformatf("v%0d result hold", idx), result, v.exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    op = 2'b00; data_in = '0; shamt = '0;

    vecs[0] = '{2'b01, 32'h8000_0000, 5'd8,  32'hFF80_0000, 6};
    vecs[1] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 6};
    vecs[2] = '{2'b10, 32'hF000_0000, 5'd4,  32'h0F00_0000, 6};
    vecs[3] = '{2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678, 1};
    vecs[4] = '{2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 6};
    vecs[5] = '{2'b01, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 6};
    vecs[6] = '{2'b00, 32'hDEAD_BEEF, 5'd5,  32'hD5B7_DDE0, 6};
    vecs[7] = '{2'b10, 32'hA5A5_A5A5, 5'd31, 32'h0000_0001, 6};
    vecs[8] = '{2'b01, 32'hA5A5_A5A5, 5'd1,  32'hD2D2_D2D2, 6};
    vecs[9] = '{2'b10, 32'hCAFE_0000, 5'd0,  32'hCAFE_0000, 1};

    step();
    step();
    reset = 1'b0;
    check("reset result", result, 32'h0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);

    for (int unsigned i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Flush mid-shift: SRA 0x80000000 by 31, flush in N+3, restart in N+4.
    drive_start(2'b01, 32'h8000_0000, 5'd31);
    step();                                    // N+1
    start = 1'b0;
    check("fl busy N+1", {31'd0, busy}, 32'd1);
    step();                                    // N+2
    step();                                    // N+3
    flush = 1'b1;
    step();                                    // N+4
    flush = 1'b0;
    check("fl busy N+4", {31'd0, busy}, 32'd0);
    check("fl done N+4", {31'd0, done}, 32'd0);
    check("fl partial", result, 32'hFFFF_FF80);
    drive_start(2'b10, 32'h0000_00F0, 5'd4);
    for (int unsigned c = 5; c <= 10; c++) begin
      step();
      start = 1'b0;
      check($sformatf("fl2 busy N+%0d", c), {31'd0, busy}, {31'd0, (c < 10)});
      check($sformatf("fl2 done N+%0d", c), {31'd0, done}, {31'd0, (c == 10)});
    end
    check("fl2 result", result, 32'h0000_000F);
    step();

    // Flush beats start in the same cycle.
    drive_start(2'b00, 32'h1111_1111, 5'd3);
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    check("flush>start busy", {31'd0, busy}, 32'd0);
    check("flush>start done", {31'd0, done}, 32'd0);
    step();
    check("flush>start idle", {31'd0, busy}, 32'd0);

    // Start while busy is ignored; start in the DONE cycle is accepted.
    drive_start(2'b00, 32'h0000_0001, 5'd4);
    step();                                    // N+1
    start = 1'b0;
    step();                                    // N+2
    drive_start(2'b10, 32'hFFFF_FFFF, 5'd1);
    step();                                    // N+3
    start = 1'b0;
    step();                                    // N+4
    step();                                    // N+5
    check("ign busy N+5", {31'd0, busy}, 32'd1);
    step();                                    // N+6
    check("ign done N+6", {31'd0, done}, 32'd1);
    check("ign result", result, 32'h0000_0010);
    drive_start(2'b01, 32'h8000_0000, 5'd8);
    step();                                    // N+7
    start = 1'b0;
    check("b2b busy N+7", {31'd0, busy}, 32'd1);
    check("b2b done N+7", {31'd0, done}, 32'd0);
    for (int unsigned c = 8; c <= 12; c++) begin
      step();
      check($sformatf("b2b done N+%0d", c), {31'd0, done}, {31'd0, (c == 12)});
    end
    check("b2b result", result, 32'hFF80_0000);
    step();

    // Reset mid-shift, then a normal shift.
    drive_start(2'b10, 32'hFFFF_FFFF, 5'd16);
    step();                                    // N+1
    start = 1'b0;
    step();                                    // N+2
    step();                                    // N+3
    reset = 1'b1;
    step();                                    // N+4
    reset = 1'b0;
    check("rst mid result", result, 32'h0);
    check("rst mid busy", {31'd0, busy}, 32'd0);
    check("rst mid done", {31'd0, done}, 32'd0);
    step();
    check("rst mid stays idle", {31'd0, busy | done}, 32'd0);
    run_vec(vecs[2], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
